// File: rtl/blowfish128_pkg.sv
// Shared types and constants for the Blowfish-128 F-function block.
// Lookup order is S0..S3 on the high half, then S0..S3 on the low half.
package blowfish128_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        DONE,
        RELEASE
    } ffunc_state_e;

    // Operation applied when the word from box N returns: load, add, xor, add.
    typedef enum logic [1:0] {
        OP_LOAD,
        OP_ADD_B,
        OP_XOR_C,
        OP_ADD_D
    } step_op_e;

    localparam int CNT_W = 4;

    localparam logic [CNT_W-1:0] LOOKUPS  = 4'd8;
    localparam logic [CNT_W-1:0] LATENCY  = 4'd10;
    localparam logic [CNT_W-1:0] HI_LAST  = 4'd4;
    localparam logic [CNT_W-1:0] LAST_CNT = LATENCY - 4'd1;

    function automatic logic [7:0] pick_byte(input logic [31:0] half,
                                             input logic [1:0]  box);
        logic [7:0] b;
        case (box)
            2'd0:    b = half[31:24];
            2'd1:    b = half[23:16];
            2'd2:    b = half[15:8];
            default: b = half[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/blowfish128_f32_step.sv
// One 32-bit accumulate step of the Blowfish F function, mod 2^32.
// Purely combinational; the caller owns the accumulator register.
module blowfish128_f32_step
    import blowfish128_pkg::*;
(
    input  step_op_e    op_i,
    input  logic [31:0] acc_i,
    input  logic [31:0] sbox_data_i,
    output logic [31:0] acc_o
);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        acc_o = sbox_data_i;
        unique case (op_i)
            OP_LOAD:  acc_o = sbox_data_i;
            OP_ADD_B: acc_o = acc_i + sbox_data_i;
            OP_XOR_C: acc_o = acc_i ^ sbox_data_i;
            OP_ADD_D: acc_o = acc_i + sbox_data_i;
            default:  acc_o = sbox_data_i;
        endcase
    end

endmodule

// File: rtl/blowfish128_ffunc.sv
// Blowfish-128 F-function: eight sequential S-box reads, one per cycle,
// producing Y = {F(X[63:32]), F(X[31:0])} with a fixed 10-edge latency.
module blowfish128_ffunc
    import blowfish128_pkg::*;
(
    input  logic        Clk,
    input  logic        RstN,
    input  logic        ffunc_enable,
    input  logic [63:0] X,
    input  logic        sbox_valid,
    output logic [63:0] Y,
    output logic        ffunc_ready,
    output logic        sbox_rd,
    output logic [9:0]  sbox_addr,
    input  logic [31:0] sbox_data
);

    ffunc_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      x_q, x_d;
    logic [63:0]      y_q, y_d;
    logic [31:0]      acc_q, acc_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      step_acc;
    logic [31:0]      half;
    logic             lookup_phase;
    logic             data_phase;
    step_op_e         step_op;

    // cnt_q k < 8 issues lookup k; read data for lookup k-1 is consumed while cnt_q = k.
    assign lookup_phase = (state_q == LOOKUP) && (cnt_q < LOOKUPS);
    assign data_phase   = (state_q == LOOKUP) && (cnt_q != '0) && (cnt_q <= LOOKUPS);
    assign step_op      = step_op_e'(cnt_q[1:0] - 2'd1);
    assign half         = cnt_q[2] ? x_q[31:0] : x_q[63:32];

    blowfish128_f32_step u_step (
        .op_i        (step_op),
        .acc_i       (acc_q),
        .sbox_data_i (sbox_data),
        .acc_o       (step_acc)
    );

    assign sbox_rd     = lookup_phase;
    assign sbox_addr   = lookup_phase ? {cnt_q[1:0], pick_byte(half, cnt_q[1:0])} : 10'd0;
    assign ffunc_ready = (state_q == DONE);
    assign Y           = y_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        hi_d    = hi_q;

        unique case (state_q)
            IDLE: begin
                if (ffunc_enable && sbox_valid) begin
                    state_d = LOOKUP;
                    x_d     = X;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end

            LOOKUP: begin
                if (!ffunc_enable) begin
                    // Abandoned request: Y keeps the last completed result.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (data_phase) begin
                        acc_d = step_acc;
                    end
                    if (cnt_q == HI_LAST) begin
                        hi_d = step_acc;
                    end
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        y_d     = {hi_q, acc_q};
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            DONE: begin
                state_d = RELEASE;
            end

            RELEASE: begin
                // A request still held high after completion must not restart.
                if (!ffunc_enable) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            hi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            hi_q    <= hi_d;
        end
    end

endmodule
